// File: rtl/lime_mem_pkg.sv
// ============================================================================
// Module : lime_mem_pkg
// Brief  : Shared types and constants for the lime memory responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lime_mem_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEF_IO_OUT_ADDR = 16'hFFFE;
  localparam logic [WORD_W-1:0] DEF_IO_IN_ADDR  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // True when every address bit above the RAM index is zero.
  function automatic logic in_ram_range(input logic [WORD_W-1:0] addr, input int aw);
    return (32'(addr) >> aw) == 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
// ============================================================================
// Module : mem_array
// Brief  : Single-port synchronous RAM, 16-bit words, registered read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : Latency-delayed RAM/MMIO responder with Ready pulse and sticky Fault.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import lime_mem_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                LATENCY     = 2,
  parameter logic [WORD_W-1:0] IO_OUT_ADDR = DEF_IO_OUT_ADDR,
  parameter logic [WORD_W-1:0] IO_IN_ADDR  = DEF_IO_IN_ADDR
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemR,
  input  logic              MemW,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] WriteData,
  input  logic [WORD_W-1:0] IoIn,
  output logic [WORD_W-1:0] ReadData,
  output logic              Ready,
  output logic              Busy,
  output logic [WORD_W-1:0] IoOut,
  output logic              Fault
);

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] read_data_q, read_data_d;
  logic [WORD_W-1:0] io_out_q, io_out_d;
  logic              fault_q, fault_d;

  logic              strobe;
  logic              in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  assign strobe   = MemR | MemW;
  assign in_range = in_ram_range(addr_q, ADDR_W);

  // The RAM sees the live address while idle so the acceptance edge already
  // starts the read; afterwards it tracks the latched address.
  assign ram_addr = (state_q == IDLE) ? Addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    io_out_d    = io_out_q;
    fault_d     = fault_q;
    ram_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && strobe) begin
          addr_d  = Addr;
          wdata_d = WriteData;
          rd_d    = MemR;
          wr_d    = MemW;
          cnt_d   = 4'(LATENCY - 1);
          armed_d = 1'b0;
          state_d = ACCESS;
        end else if (!strobe) begin
          armed_d = 1'b1;
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (rd_q && wr_q) begin
            fault_d = 1'b1;
          end else if (rd_q) begin
            if (addr_q == IO_IN_ADDR) begin
              read_data_d = IoIn;
            end else if (addr_q == IO_OUT_ADDR) begin
              read_data_d = io_out_q;
            end else if (in_range) begin
              read_data_d = ram_rdata;
            end else begin
              read_data_d = '0;
              fault_d     = 1'b1;
            end
          end else begin
            // Writes to the input port are silently ignored.
            if (addr_q == IO_OUT_ADDR) begin
              io_out_d = wdata_q;
            end else if (addr_q == IO_IN_ADDR) begin
              io_out_d = io_out_q;
            end else if (in_range) begin
              ram_we = 1'b1;
            end else begin
              fault_d = 1'b1;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        if (!strobe) begin
          armed_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
      io_out_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
      io_out_q    <= io_out_d;
      fault_q     <= fault_d;
    end
  end

  assign ReadData = read_data_q;
  assign Ready    = (state_q == RESP);
  assign Busy     = (state_q != IDLE);
  assign IoOut    = io_out_q;
  assign Fault    = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module : tb_mem_responder
// Brief  : Randomized scoreboard bench for mem_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        MemR = 1'b0;
  logic        MemW = 1'b0;
  logic [15:0] Addr = 16'h0;
  logic [15:0] WriteData = 16'h0;
  logic [15:0] IoIn = 16'h0;
  logic [15:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic [15:0] IoOut;
  logic        Fault;

  mem_responder #(
    .ADDR_W      (10),
    .LATENCY     (LAT),
    .IO_OUT_ADDR (16'hFFFE),
    .IO_IN_ADDR  (16'hFFFF)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .MemR      (MemR),
    .MemW      (MemW),
    .Addr      (Addr),
    .WriteData (WriteData),
    .IoIn      (IoIn),
    .ReadData  (ReadData),
    .Ready     (Ready),
    .Busy      (Busy),
    .IoOut     (IoOut),
    .Fault     (Fault)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] rd;
    logic        fault;
    logic [15:0] io;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference state: the first 16 RAM words, output port, last read, fault.
  logic [15:0] m_ram [16];
  logic [15:0] m_io = 16'h0;
  logic [15:0] m_rd = 16'h0;
  logic        m_fault = 1'b0;

  int busy_from = -1;
  int busy_until = -1;
  int next_ok = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_op(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] ioin, input int rdy);
    if (rd && wr) begin
      m_fault = 1'b1;
    end else if (rd) begin
      if (a == 16'hFFFF) m_rd = ioin;
      else if (a == 16'hFFFE) m_rd = m_io;
      else if (a < 16'd1024) m_rd = m_ram[a[3:0]];
      else begin
        m_rd = 16'h0;
        m_fault = 1'b1;
      end
    end else begin
      if (a == 16'hFFFE) m_io = wd;
      else if (a == 16'hFFFF) m_io = m_io;
      else if (a < 16'd1024) m_ram[a[3:0]] = wd;
      else m_fault = 1'b1;
    end
    sb.push_back('{rdy, m_rd, m_fault, m_io});
  endtask

  // Issue one request; strobe is held for 'hold' edges, then address bus is scrambled.
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] ioin,
                       input int hold, input bit push);
    int acc;
    while (cyc + 1 < next_ok) @(negedge CLK);
    MemR = rd;
    MemW = wr;
    Addr = a;
    WriteData = wd;
    IoIn = ioin;
    acc = cyc + 1;
    if (push) model_op(rd, wr, a, wd, ioin, acc + LAT);
    busy_from = acc;
    busy_until = acc + LAT;
    next_ok = (acc + LAT + 2 > acc + hold + 1) ? acc + LAT + 2 : acc + hold + 1;
    repeat (hold) @(negedge CLK);
    MemR = 1'b0;
    MemW = 1'b0;
    Addr = 16'($urandom);
    WriteData = 16'($urandom);
  endtask

  task automatic rand_op(input bit allow_fault);
    int k;
    logic [15:0] a;
    logic rd;
    logic wr;
    k = $urandom_range(0, 9);
    if (k < 6) a = 16'($urandom_range(0, 15));
    else if (k == 6) a = 16'hFFFE;
    else if (k == 7) a = 16'hFFFF;
    else if (allow_fault) a = 16'($urandom_range(16'h0400, 16'hFFFD));
    else a = 16'($urandom_range(0, 15));
    rd = 1'($urandom_range(0, 1));
    wr = !rd;
    if (allow_fault && $urandom_range(0, 9) == 0) begin
      rd = 1'b1;
      wr = 1'b1;
    end
    do_op(rd, wr, a, 16'($urandom), 16'($urandom), $urandom_range(1, 4), 1'b1);
  endtask

  // Monitor: Busy every cycle, and every Ready pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #3;
      if (!Reset) begin
        chk("busy", 32'(Busy), 32'(busy_from >= 0 && cyc >= busy_from && cyc <= busy_until));
        if (Ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got Ready=1 expected no response (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("ready_cycle", 32'(cyc), 32'(e.cyc));
            chk("read_data", 32'(ReadData), 32'(e.rd));
            chk("fault", 32'(Fault), 32'(e.fault));
            chk("io_out", 32'(IoOut), 32'(e.io));
          end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_ready: got no Ready expected one at cycle %0d", e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("rst_read_data", 32'(ReadData), 32'h0);
    chk("rst_ready", 32'(Ready), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_io_out", 32'(IoOut), 32'h0);
    chk("rst_fault", 32'(Fault), 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    next_ok = cyc + 1;

    for (int i = 0; i < 16; i++) do_op(1'b0, 1'b1, 16'(i), 16'($urandom), 16'h0, 1, 1'b1);

    do_op(1'b0, 1'b1, 16'd5, 16'h1234, 16'h0, 1, 1'b1);
    do_op(1'b1, 1'b0, 16'd5, 16'h0, 16'h0, 1, 1'b1);
    do_op(1'b1, 1'b0, 16'd5, 16'h0, 16'h0, 6, 1'b1);
    do_op(1'b1, 1'b0, 16'd5, 16'h0, 16'h0, 1, 1'b1);
    do_op(1'b0, 1'b1, 16'hFFFE, 16'hBEEF, 16'h0, 1, 1'b1);
    do_op(1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h00A5, 1, 1'b1);

    for (int i = 0; i < 40; i++) rand_op(1'b0);

    do_op(1'b1, 1'b0, 16'h0400, 16'h0, 16'h0, 1, 1'b1);
    do_op(1'b0, 1'b1, 16'h0400, 16'hDEAD, 16'h0, 1, 1'b1);
    do_op(1'b1, 1'b0, 16'd0, 16'h0, 16'h0, 1, 1'b1);
    do_op(1'b1, 1'b1, 16'd3, 16'hCAFE, 16'h0, 2, 1'b1);
    do_op(1'b1, 1'b0, 16'd3, 16'h0, 16'h0, 1, 1'b1);

    // Reset lands while the write to address 7 is still in ACCESS.
    do_op(1'b1, 1'b0, 16'd7, 16'h0, 16'h0, 1, 1'b1);
    do_op(1'b0, 1'b1, 16'd7, 16'h5555, 16'h0, 1, 1'b0);
    busy_from = -1;
    Reset = 1'b1;
    #1;
    chk("abort_read_data", 32'(ReadData), 32'h0);
    chk("abort_ready", 32'(Ready), 32'h0);
    chk("abort_busy", 32'(Busy), 32'h0);
    chk("abort_io_out", 32'(IoOut), 32'h0);
    chk("abort_fault", 32'(Fault), 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    m_rd = 16'h0;
    m_io = 16'h0;
    m_fault = 1'b0;
    next_ok = cyc + 1;
    do_op(1'b1, 1'b0, 16'd7, 16'h0, 16'h0, 1, 1'b1);

    for (int i = 0; i < 40; i++) rand_op(1'b1);

    repeat (LAT + 5) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle lime datapath. Services the MemR/MemW strobes and IoD-selected address issued by the control FSM.
- Accesses a word-addressed 16-bit RAM plus two memory-mapped I/O words, after a configurable wait latency.
- Returns read data and a one-cycle Ready pulse.
- Sits between the datapath's memory address/data buses and the on-chip RAM array.

Parameters:
- ADDR_W, 10, RAM index width; RAM depth = 2**ADDR_W words of 16 bits.
- LATENCY, 2, cycles from request acceptance to Ready; legal range 1..15.
- IO_OUT_ADDR, 16'hFFFE, address of the writable output port register.
- IO_IN_ADDR, 16'hFFFF, address of the read-only input port.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- MemR  input  1  read request strobe (level).
- MemW  input  1  write request strobe (level).
- Addr  input  16  word address.
- WriteData  input  16  store data.
- IoIn  input  16  external input port value.
- ReadData  output  16  registered read result.
- Ready  output  1  one-cycle completion pulse.
- Busy  output  1  high whenever state != IDLE.
- IoOut  output  16  output port register.
- Fault  output  1  sticky error flag.

Behaviour:
- Reset (async, Reset high):
  - state=IDLE, armed=1.
  - ReadData=0, Ready=0, Busy=0, IoOut=0, Fault=0.
  - RAM contents are not cleared.
  - A reset during ACCESS or RESP aborts the operation: no RAM or IoOut write occurs.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If armed and (MemR|MemW) is sampled high at an edge, latch Addr, WriteData, MemR and MemW.
  - On that edge: load cnt=LATENCY-1, clear armed, go to ACCESS.
  - If the strobe is low at an edge, set armed=1.
- ACCESS:
  - At each edge, if cnt!=0 then cnt--.
  - If cnt==0, perform the access on that edge and go to RESP.
  - RESP is therefore entered exactly LATENCY edges after the acceptance edge.
- RESP:
  - Ready=1 for exactly one cycle, then IDLE on the next edge.
  - In RESP, set armed=1 if the strobe is low. Otherwise armed stays 0, so a strobe still held high is not re-accepted.
  - A new request needs the strobe low for at least one edge after acceptance.
- Access decode, on the RESP-entry edge, using latched values:
  - Read, Addr==IO_IN_ADDR: ReadData<=IoIn (sampled on that edge).
  - Read, Addr==IO_OUT_ADDR: ReadData<=IoOut.
  - Read, Addr<2**ADDR_W: ReadData<=RAM[Addr[ADDR_W-1:0]].
  - Read, otherwise: ReadData<=0, Fault<=1.
  - Write, Addr==IO_OUT_ADDR: IoOut<=WriteData.
  - Write, Addr==IO_IN_ADDR: ignored, no fault.
  - Write, in range: RAM write.
  - Write, out of range: dropped, Fault<=1.
- MemR and MemW both high at acceptance: no access, ReadData unchanged, Fault<=1, Ready still pulses.
- ReadData holds its value until the next completed read; writes never change it.
- Strobe changes during ACCESS are ignored; Addr and WriteData are taken from the latched copies.
- Fault clears only on Reset.
- Busy is purely decoded from state. Ready is decoded as state==RESP.
- Address width: Addr is 16 bits, and the in-range check compares Addr[15:ADDR_W]==0. MMIO addresses take priority over the range check.
- Timing with LATENCY=1: accept at edge 0, Ready during cycle after edge 1. Back-to-back minimum spacing is LATENCY+2 cycles.

Decomposition:
- Package lime_mem_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - Default IO_OUT_ADDR and IO_IN_ADDR constants.
  - Word width constant 16.
- Sub-module mem_array:
  - Single-port synchronous RAM, parameter ADDR_W.
  - Inputs: we, addr, wdata. Output: rdata.
  - Write-first is not required.
- mem_responder owns the FSM, latches, MMIO decode, Fault and armed logic.

Test Plan:
- LATENCY=2. Write 16'h1234 to addr 5 (MemW one cycle), then after Ready read addr 5 (MemR one cycle) -> Ready pulses 2 edges after each acceptance; ReadData=16'h1234; Busy high for 3 cycles per op.
- MemR held high for 6 cycles at addr 5 -> exactly one Ready pulse. Drop MemR one cycle, reassert -> second Ready.
- Write 16'hBEEF to IO_OUT_ADDR -> IoOut=16'hBEEF after the RESP-entry edge. IoIn=16'h00A5 and read IO_IN_ADDR -> ReadData=16'h00A5; Fault=0.
- Read addr 16'h0400 with ADDR_W=10 -> ReadData=0, Fault=1. Write out of range -> RAM[0] unchanged; Fault stays 1 until Reset.
- MemR and MemW both high -> Ready pulses; ReadData keeps its previous value; RAM and IoOut unchanged; Fault=1.
- Assert Reset during ACCESS of a write of 16'h5555 to addr 7 -> outputs reach reset values immediately; subsequent read of addr 7 returns its prior contents.
